scan_code_transmitter: RTL and testbench
========================================

SCAN_CODE_TRANSMITTER -- requirements
Module: scan_code_transmitter

Interface
REQ-001 The block SHALL have parameter HALF_PERIOD, default 4: number of clk cycles in each high or low phase of serialClk; legal values are 2 to 255.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all flops are rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port txData, input, 8 bits: scan code to send, sampled on acceptance.
REQ-005 The block SHALL have port txValid, input, 1 bit: request to send txData.
REQ-006 The block SHALL have port txReady, output, 1 bit: block is idle and will accept a request.
REQ-007 The block SHALL have port serialClk, output, 1 bit: generated frame clock; idles high.
REQ-008 The block SHALL have port serialData, output, 1 bit: frame data line; idles high.
REQ-009 The block SHALL have port txDone, output, 1 bit: one-cycle pulse when a frame has completed.

Function
REQ-010 The block SHALL send an 11-bit frame in this order:
- start bit 0;
- txData[0] through txData[7], LSB first;
- odd parity bit, such that the 8 data bits plus parity contain an odd number of ones;
- stop bit 1.
REQ-011 Acceptance SHALL occur on a rising edge where txValid=1 and txReady=1; at that edge the block SHALL latch txData and parity, and enter SHIFT.
REQ-012 The state machine SHALL have exactly three states: IDLE, SHIFT and GUARD.
REQ-013 The state transitions SHALL be:
- IDLE to SHIFT on acceptance;
- SHIFT to GUARD after bit 10 completes;
- GUARD to IDLE after 2*HALF_PERIOD cycles.
REQ-014 In IDLE, outputs SHALL be txReady=1, serialClk=1 and serialData=1.
REQ-015 In SHIFT and GUARD, txReady SHALL be 0, and txValid SHALL be ignored.
REQ-016 In SHIFT, the block SHALL count bits with a phase counter cnt (0 to 2*HALF_PERIOD-1) and a bit index bitIdx (0 to 10), both 0 in the first SHIFT cycle.
REQ-017 In SHIFT, serialClk SHALL be 1 while cnt<HALF_PERIOD and 0 otherwise.
REQ-018 In SHIFT, serialData SHALL equal frame bit bitIdx for the whole bit period, so it changes only at the start of a high phase and is stable across the falling edge.
REQ-019 When cnt=2*HALF_PERIOD-1, cnt SHALL wrap to 0 and bitIdx SHALL increment; when this happens with bitIdx=10, the state SHALL move to GUARD.
REQ-020 SHIFT SHALL last exactly 22*HALF_PERIOD cycles.
REQ-021 In GUARD, serialClk and serialData SHALL both be 1 for exactly 2*HALF_PERIOD cycles.
REQ-022 txDone SHALL be 1 for exactly the first IDLE cycle after GUARD, and 0 at all other times.
REQ-023 txReady SHALL be 1 in that same cycle, so a held txValid starts the next frame with no idle gap beyond that cycle.
REQ-024 From the acceptance edge to txReady returning to 1, the busy time SHALL be 24*HALF_PERIOD cycles.
REQ-025 serialClk and serialData SHALL be driven directly from flops, with no combinational path from any input.
REQ-026 Changes on txData after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-027 When rst_n=0, the block SHALL immediately, without waiting for clk, force:
- state=IDLE, cnt=0, bitIdx=0;
- serialClk=1, serialData=1;
- txReady=1, txDone=0.
REQ-028 A reset in the middle of a frame SHALL abort the frame; no txDone SHALL be produced for it.
REQ-029 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification (HALF_PERIOD=4)
REQ-030 Send 0x1C -> at the falling edges of serialClk, serialData SHALL read 0,0,0,1,1,1,0,0,0,0,1 (parity 0); txDone SHALL occur 96 cycles after the acceptance edge.
REQ-031 Send 0x00 -> parity bit SHALL be 1; send 0xFF -> parity bit SHALL be 1; each frame SHALL show exactly 11 serialClk low pulses of 4 cycles each.
REQ-032 Hold txValid=1 with txData=0xA5 then 0x3C -> the second acceptance SHALL occur in the txDone cycle, and the two frames SHALL be separated only by the 8-cycle GUARD.
REQ-033 Pulse txValid with new data during SHIFT -> the request SHALL be ignored, the frame SHALL be unchanged, and no second frame SHALL start.
REQ-034 Assert rst_n=0 at bit 5 of a frame -> serialClk=1, serialData=1 and txReady=1 SHALL appear before the next clk edge, with no txDone; a new frame after release SHALL be correct.
REQ-035 Change txData every cycle during a frame for 0x5A -> the captured bits SHALL still decode to 0x5A with parity 1.

Source files
------------

// File: rtl/scan_code_transmitter.sv
// Serial scan-code transmitter: start bit, eight data bits LSB first, odd parity, stop bit,
// with a generated frame clock and a guard interval before the next frame is accepted.
module scan_code_transmitter #(
    parameter int HALF_PERIOD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic       serialClk,
    output logic       serialData,
    output logic       txDone
);
    // state | meaning
    // IDLE  | waiting for a request; lines high, txReady high
    // SHIFT | 11 frame bits, each one serialClk period (high phase then low phase)
    // GUARD | lines held high for one serialClk period before returning to IDLE

    localparam int CW = $clog2(2 * HALF_PERIOD);
    localparam logic [CW-1:0] LAST_CNT = CW'(2 * HALF_PERIOD - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(HALF_PERIOD);

    typedef enum logic [1:0] {IDLE, SHIFT, GUARD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [3:0]    bit_idx;
    logic [10:0]   frame;

    assign cnt_next = (cnt == LAST_CNT) ? '0 : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            frame      <= '1;
            serialClk  <= 1'b1;
            serialData <= 1'b1;
            txReady    <= 1'b1;
            txDone     <= 1'b0;
        end else begin
            txDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (txValid && txReady) begin
                        state      <= SHIFT;
                        cnt        <= '0;
                        bit_idx    <= '0;
                        frame      <= {1'b1, ~^txData, txData, 1'b0};
                        serialClk  <= 1'b1;
                        serialData <= 1'b0;
                        txReady    <= 1'b0;
                    end
                end
                SHIFT: begin
                    cnt       <= cnt_next;
                    serialClk <= (cnt_next < HALF_CNT);
                    if (cnt == LAST_CNT) begin
                        if (bit_idx == 4'd10) begin
                            state      <= GUARD;
                            bit_idx    <= '0;
                            serialClk  <= 1'b1;
                            serialData <= 1'b1;
                        end else begin
                            // frame[0] is always the bit on the line; shift in stop-level ones
                            bit_idx    <= bit_idx + 4'd1;
                            frame      <= {1'b1, frame[10:1]};
                            serialData <= frame[1];
                        end
                    end
                end
                GUARD: begin
                    cnt <= cnt_next;
                    if (cnt == LAST_CNT) begin
                        state   <= IDLE;
                        txReady <= 1'b1;
                        txDone  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scan_code_transmitter.sv
// Scoreboard bench: stimulus queues hand-computed frames, a negedge monitor decodes the line
// and checks handshake timing against a cycle-count model of the 24*HP busy window.
module tb_scan_code_transmitter;
    localparam int HP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] txData = 8'h00;
    logic       txValid = 1'b0;
    logic       txReady, serialClk, serialData, txDone;

    scan_code_transmitter #(.HALF_PERIOD(HP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .txData     (txData),
        .txValid    (txValid),
        .txReady    (txReady),
        .serialClk  (serialClk),
        .serialData (serialData),
        .txDone     (txDone)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [10:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor / model state
    int          ready_at = 0;
    int          done_at = -1;
    int          cur_acc = -1000;
    int          lowcnt = 0;
    int          nbits = 0;
    int          off = 0;
    logic        busy = 1'b0;
    logic        prev_sclk = 1'b1;
    logic [10:0] cap = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            ready_at  = 0;
            done_at   = -1;
            cur_acc   = -1000;
            lowcnt    = 0;
            nbits     = 0;
            prev_sclk = 1'b1;
            exp_q.delete();
        end else begin
            busy = (cyc < ready_at);
            chk("txReady", int'(txReady), int'(!busy));
            chk("txDone", int'(txDone), int'(cyc == done_at));
            if (!busy) begin
                chk("idle_clk", int'(serialClk), 1);
                chk("idle_data", int'(serialData), 1);
            end else begin
                off = cyc - cur_acc;
                if (off >= 22 * HP) begin
                    chk("guard_clk", int'(serialClk), 1);
                    chk("guard_data", int'(serialData), 1);
                end else begin
                    chk("shift_clk", int'(serialClk), int'((off % (2 * HP)) < HP));
                end
            end
            if (prev_sclk && !serialClk) begin
                cap = {serialData, cap[10:1]};
                nbits++;
                if (nbits == 11) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame: unexpected frame 0x%03h with nothing queued", cap);
                    end else begin
                        chk("frame", int'(cap), int'(exp_q.pop_front()));
                    end
                    nbits = 0;
                end
            end
            if (!serialClk) lowcnt++;
            else if (!prev_sclk) begin
                chk("low_pulse_len", lowcnt, HP);
                lowcnt = 0;
            end
            prev_sclk = serialClk;
            if (!busy && txValid) begin
                cur_acc  = cyc + 1;
                ready_at = cyc + 1 + 24 * HP;
                done_at  = ready_at;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [10:0] f, input bit hold, output int waits);
        exp_q.push_back(f);
        txData  = d;
        txValid = 1'b1;
        waits   = 0;
        while (!txReady && waits < 1000) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= 1000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: txReady low for %0d cycles, required 1", waits);
        end
        @(posedge clk); #1;
        if (!hold) txValid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!txDone && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (!txDone) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: txDone=0 after %0d cycles, required 1", limit);
        end
    endtask

    int w;
    int n;

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_clk", int'(serialClk), 1);
        chk("rst_data", int'(serialData), 1);
        chk("rst_ready", int'(txReady), 1);
        chk("rst_done", int'(txDone), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // frame layout {stop, parity, data[7:0], start}
        send(8'h1C, 11'b1_0_0001_1100_0, 1'b0, w);
        wait_done(200);
        @(posedge clk); #1;
        send(8'h00, 11'b1_1_0000_0000_0, 1'b0, w);
        wait_done(200);
        send(8'hFF, 11'b1_1_1111_1111_0, 1'b0, w);
        wait_done(200);
        @(posedge clk); #1;

        // held request: second frame accepted in the txDone cycle
        send(8'hA5, 11'b1_1_1010_0101_0, 1'b1, w);
        txData = 8'h3C;
        exp_q.push_back(11'b1_1_0011_1100_0);
        wait_done(200);
        chk("b2b_ready_in_done", int'(txReady), 1);
        @(posedge clk); #1;
        txValid = 1'b0;
        chk("b2b_accepted", int'(txReady), 0);
        wait_done(200);
        @(posedge clk); #1;

        // request pulse during SHIFT must be ignored
        send(8'h07, 11'b1_0_0000_0111_0, 1'b0, w);
        repeat (30) @(posedge clk);
        #1;
        txData  = 8'hE1;
        txValid = 1'b1;
        @(posedge clk); #1;
        txValid = 1'b0;
        chk("ignored_busy", int'(txReady), 0);
        wait_done(200);
        repeat (40) @(posedge clk);
        #1;

        // txData churn after acceptance
        send(8'h5A, 11'b1_1_0101_1010_0, 1'b0, w);
        n = 0;
        while (!txDone && n < 200) begin
            txData = 8'($urandom);
            @(posedge clk); #1;
            n++;
        end
        chk("churn_done_seen", int'(txDone), 1);
        @(posedge clk); #1;

        // asynchronous abort in the low phase of bit 5
        send(8'h6B, 11'b1_0_0110_1011_0, 1'b0, w);
        repeat (45) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_clk", int'(serialClk), 1);
        chk("abort_data", int'(serialData), 1);
        chk("abort_ready", int'(txReady), 1);
        chk("abort_done", int'(txDone), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(8'h81, 11'b1_1_1000_0001_0, 1'b0, w);
        chk("first_edge_accept", w, 0);
        wait_done(200);
        repeat (20) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
